// File: rtl/alu_pkg.sv
// Shared opcode encodings, opcode classification helpers and the FSM state
// type for the shared-ALU arbiter.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } alu_arb_state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        logic legal;
        case (op)
            OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_AND,
            OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA: legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic is_shift_op(input logic [3:0] op);
        logic shift;
        case (op)
            OP_SLL, OP_SRL, OP_SRA: shift = 1'b1;
            default:                shift = 1'b0;
        endcase
        return shift;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational 32-bit ALU; unknown opcodes produce zero.
module alu_core
    import alu_pkg::*;
(
    input  logic [3:0]  opcode_in,
    input  logic [31:0] op_a_in,
    input  logic [31:0] op_b_in,
    output logic [31:0] result_out
);

    // Opcode decode and evaluation.
    always_comb begin
        result_out = 32'h0000_0000;
        case (opcode_in)
            OP_ADD:  result_out = op_a_in + op_b_in;
            OP_SUB:  result_out = op_a_in - op_b_in;
            OP_SLT:  result_out = {31'd0, ($signed(op_a_in) < $signed(op_b_in))};
            OP_SLTU: result_out = {31'd0, (op_a_in < op_b_in)};
            OP_AND:  result_out = op_a_in & op_b_in;
            OP_OR:   result_out = op_a_in | op_b_in;
            OP_XOR:  result_out = op_a_in ^ op_b_in;
            OP_SLL:  result_out = op_a_in << op_b_in[4:0];
            OP_SRL:  result_out = op_a_in >> op_b_in[4:0];
            OP_SRA:  result_out = $unsigned($signed(op_a_in) >>> op_b_in[4:0]);
            default: result_out = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search begins one past the last
// requester granted and wraps; the pointer moves only when a grant is taken.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic [NUM_REQ-1:0] req_in,
    input  logic               advance_in,
    output logic [NUM_REQ-1:0] grant_out
);

    logic [ID_W-1:0]    last_grant_q;
    logic [ID_W-1:0]    last_grant_d;
    logic [NUM_REQ-1:0] grant_s;
    logic [ID_W-1:0]    grant_idx_s;
    logic [ID_W:0]      cand_s;
    logic               found_s;

    // Priority search starting after last_grant, wrapping modulo NUM_REQ.
    always_comb begin
        grant_s     = {NUM_REQ{1'b0}};
        grant_idx_s = {ID_W{1'b0}};
        cand_s      = {(ID_W+1){1'b0}};
        found_s     = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s = {1'b0, last_grant_q} + (ID_W+1)'(k);
            if (cand_s >= (ID_W+1)'(NUM_REQ)) begin
                cand_s = cand_s - (ID_W+1)'(NUM_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && req_in[cand_s[ID_W-1:0]]) begin
                grant_s[cand_s[ID_W-1:0]] = 1'b1;
                grant_idx_s               = cand_s[ID_W-1:0];
                found_s                   = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer update only when the owner actually takes the grant.
    always_comb begin
        if (advance_in && found_s) begin
            last_grant_d = grant_idx_s;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Last-grant pointer; reset value gives requester 0 first priority.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            last_grant_q <= ID_W'(NUM_REQ - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign grant_out = grant_s;

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between NUM_REQ requesters: round-robin accept, registered
// operands and result, response held under valid/ready until consumed.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [NUM_REQ-1:0]    req_valid_in,
    output logic [NUM_REQ-1:0]    req_ready_out,
    input  logic [4*NUM_REQ-1:0]  req_opcode_in,
    input  logic [32*NUM_REQ-1:0] req_op_1_in,
    input  logic [32*NUM_REQ-1:0] req_op_2_in,
    output logic [NUM_REQ-1:0]    rsp_valid_out,
    input  logic [NUM_REQ-1:0]    rsp_ready_in,
    output logic [31:0]           rsp_result_out,
    output logic                  rsp_err_out,
    output logic                  busy_out
);

    alu_arb_state_t     state_q, state_d;
    logic [3:0]         opcode_q, opcode_d;
    logic [31:0]        op1_q, op1_d;
    logic [31:0]        op2_q, op2_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [31:0]        result_q, result_d;
    logic               err_q, err_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic               busy_q, busy_d;

    logic [NUM_REQ-1:0] grant_s;
    logic               in_idle_s;
    logic               rsp_fire_s;
    logic [3:0]         sel_opcode_s;
    logic [31:0]        sel_op1_s;
    logic [31:0]        sel_op2_s;
    logic [ID_W-1:0]    sel_id_s;
    logic [31:0]        alu_op2_s;
    logic [31:0]        alu_result_s;

    assign in_idle_s  = (state_q == ST_IDLE);
    assign rsp_fire_s = rsp_ready_in[id_q];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .req_in     (req_valid_in),
        .advance_in (in_idle_s),
        .grant_out  (grant_s)
    );

    // Grants are only visible while idle; elsewhere requesters must wait.
    assign req_ready_out = in_idle_s ? grant_s : {NUM_REQ{1'b0}};

    // Route the granted requester's fields towards the capture registers.
    always_comb begin
        sel_opcode_s = 4'd0;
        sel_op1_s    = 32'd0;
        sel_op2_s    = 32'd0;
        sel_id_s     = {ID_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s[i]) begin
                sel_opcode_s = req_opcode_in[4*i +: 4];
                sel_op1_s    = req_op_1_in[32*i +: 32];
                sel_op2_s    = req_op_2_in[32*i +: 32];
                sel_id_s     = ID_W'(i);
            end else begin
                sel_id_s = sel_id_s;
            end
        end
    end

    // Shift amounts are limited to five bits before they reach the ALU.
    assign alu_op2_s = is_shift_op(opcode_q) ? {27'd0, op2_q[4:0]} : op2_q;

    alu_core u_alu_core (
        .opcode_in  (opcode_q),
        .op_a_in    (op1_q),
        .op_b_in    (alu_op2_s),
        .result_out (alu_result_s)
    );

    // FSM next-state, capture and response control.
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        id_d        = id_q;
        result_d    = result_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (|grant_s) begin
                    opcode_d = sel_opcode_s;
                    op1_d    = sel_op1_s;
                    op2_d    = sel_op2_s;
                    id_d     = sel_id_s;
                    state_d  = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (is_legal_op(opcode_q)) begin
                    result_d = alu_result_s;
                    err_d    = 1'b0;
                end else begin
                    result_d = 32'd0;
                    err_d    = 1'b1;
                end
                rsp_valid_d       = {NUM_REQ{1'b0}};
                rsp_valid_d[id_q] = 1'b1;
                state_d           = ST_HOLD;
            end
            ST_HOLD: begin
                if (rsp_fire_s) begin
                    rsp_valid_d = {NUM_REQ{1'b0}};
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                rsp_valid_d = {NUM_REQ{1'b0}};
                state_d     = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, capture and output registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= ST_IDLE;
            opcode_q    <= 4'd0;
            op1_q       <= 32'd0;
            op2_q       <= 32'd0;
            id_q        <= {ID_W{1'b0}};
            result_q    <= 32'd0;
            err_q       <= 1'b0;
            rsp_valid_q <= {NUM_REQ{1'b0}};
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            id_q        <= id_d;
            result_q    <= result_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_valid_out  = rsp_valid_q;
    assign rsp_result_out = result_q;
    assign rsp_err_out    = err_q;
    assign busy_out       = busy_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: stimulus pushes hand-computed
// expectations, a negedge monitor pops them on each response handshake.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [1:0]  req_valid_in;
    logic [1:0]  req_ready_out;
    logic [7:0]  req_opcode_in;
    logic [63:0] req_op_1_in;
    logic [63:0] req_op_2_in;
    logic [1:0]  rsp_valid_out;
    logic [1:0]  rsp_ready_in;
    logic [31:0] rsp_result_out;
    logic        rsp_err_out;
    logic        busy_out;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    alu_share_arbiter #(.NUM_REQ(2)) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .req_valid_in   (req_valid_in),
        .req_ready_out  (req_ready_out),
        .req_opcode_in  (req_opcode_in),
        .req_op_1_in    (req_op_1_in),
        .req_op_2_in    (req_op_2_in),
        .rsp_valid_out  (rsp_valid_out),
        .rsp_ready_in   (rsp_ready_in),
        .rsp_result_out (rsp_result_out),
        .rsp_err_out    (rsp_err_out),
        .busy_out       (busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int id, input logic [31:0] r, input logic e);
        exp_t x;
        x.id  = id;
        x.res = r;
        x.err = e;
        sb_q.push_back(x);
    endtask

    task automatic set_req(input int id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_opcode_in[id*4 +: 4] = op;
        req_op_1_in[id*32 +: 32] = a;
        req_op_2_in[id*32 +: 32] = b;
    endtask

    // Response monitor: every handshake must match the oldest expectation.
    always @(negedge clk_in) begin
        if (rst_n_in && ((rsp_valid_out & rsp_ready_in) != 2'b00)) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: valid=%b result=%h none expected", rsp_valid_out, rsp_result_out);
            end else begin
                mon_e = sb_q.pop_front();
                chk("rsp_owner", {30'd0, rsp_valid_out}, 32'd1 << mon_e.id);
                chk("rsp_result", rsp_result_out, mon_e.res);
                chk("rsp_err", {31'd0, rsp_err_out}, {31'd0, mon_e.err});
            end
        end
    end

    task automatic wait_drain(input string nm);
        bit done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk_in);
            #1;
            if (sb_q.size() == 0) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain: got %0d pending expected 0", nm, sb_q.size());
            sb_q.delete();
        end
    endtask

    // One request from an otherwise idle requester set; leaves the bench at
    // the negedge of the first HOLD cycle.
    task automatic issue(input int id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input logic exp_e, input logic [1:0] rspr);
        bit got = 1'b0;
        @(posedge clk_in);
        #1;
        rsp_ready_in = rspr;
        set_req(id, op, a, b);
        req_valid_in[id] = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk_in);
            if (req_ready_out != 2'b00) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL grant_timeout: got no grant expected grant to %0d", id);
        end else begin
            chk("grant", {30'd0, req_ready_out}, 32'd1 << id);
            push_exp(id, exp_r, exp_e);
        end
        @(posedge clk_in);
        #1;
        req_valid_in[id] = 1'b0;
        @(negedge clk_in);
        chk("exec_rsp_valid", {30'd0, rsp_valid_out}, 32'd0);
        chk("exec_busy", {31'd0, busy_out}, 32'd1);
        @(negedge clk_in);
        chk("hold_rsp_valid", {30'd0, rsp_valid_out}, 32'd1 << id);
    endtask

    initial begin
        int   grants;
        int   last_c;
        int   exp_g;
        int   gid;

        rst_n_in      = 1'b0;
        req_valid_in  = 2'b00;
        rsp_ready_in  = 2'b00;
        req_opcode_in = 8'd0;
        req_op_1_in   = 64'd0;
        req_op_2_in   = 64'd0;
        repeat (2) @(negedge clk_in);
        chk("rst_req_ready", {30'd0, req_ready_out}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp_valid_out}, 32'd0);
        chk("rst_result", rsp_result_out, 32'd0);
        chk("rst_err", {31'd0, rsp_err_out}, 32'd0);
        chk("rst_busy", {31'd0, busy_out}, 32'd0);
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;

        // Contention: grants alternate from requester 0, three cycles apart.
        @(posedge clk_in);
        #1;
        set_req(0, OP_ADD, 32'd5, 32'd3);
        set_req(1, OP_SUB, 32'd3, 32'd5);
        rsp_ready_in = 2'b11;
        req_valid_in = 2'b11;
        grants = 0;
        last_c = 0;
        exp_g  = 0;
        for (int c = 0; c < 40 && grants < 4; c++) begin
            @(negedge clk_in);
            if (req_ready_out != 2'b00) begin
                chk("cont_grant", {30'd0, req_ready_out}, 32'd1 << exp_g);
                if (grants > 0) chk("cont_spacing", c - last_c, 32'd3);
                last_c = c;
                gid = req_ready_out[1] ? 1 : 0;
                push_exp(gid, (gid == 0) ? 32'h0000_0008 : 32'hFFFF_FFFE, 1'b0);
                exp_g = 1 - exp_g;
                grants++;
            end
        end
        chk("cont_grant_count", grants, 32'd4);
        @(posedge clk_in);
        #1;
        req_valid_in = 2'b00;
        wait_drain("cont");

        // Single request with wrap-around add.
        issue(0, OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 2'b11);
        wait_drain("add");

        // Backpressure: response held, other ready bit and new requests ignored.
        issue(1, OP_SRA, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 2'b00);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_in);
            #1;
            set_req(0, OP_OR, 32'd1, 32'd2);
            req_valid_in[0] = 1'b1;
            rsp_ready_in    = 2'b01;
            @(negedge clk_in);
            chk("bp_result", rsp_result_out, 32'hF800_0000);
            chk("bp_rsp_valid", {30'd0, rsp_valid_out}, 32'd2);
            chk("bp_req_ready", {30'd0, req_ready_out}, 32'd0);
            chk("bp_busy", {31'd0, busy_out}, 32'd1);
        end
        @(posedge clk_in);
        #1;
        req_valid_in = 2'b00;
        rsp_ready_in = 2'b10;
        wait_drain("bp");

        // Illegal opcodes, then legal operations across the opcode set.
        issue(0, 4'b1111, 32'h1234_5678, 32'h0000_0009, 32'h0000_0000, 1'b1, 2'b11);
        wait_drain("ill_f");
        issue(0, OP_SLTU, 32'd1, 32'd2, 32'h0000_0001, 1'b0, 2'b11);
        wait_drain("sltu");
        issue(1, 4'b1001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 2'b11);
        wait_drain("ill_9");
        issue(0, OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 2'b11);
        wait_drain("slt");
        issue(1, OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 2'b11);
        wait_drain("sltu_big");
        issue(0, OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 2'b11);
        wait_drain("and");
        issue(1, OP_OR, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0, 2'b11);
        wait_drain("or");
        issue(0, OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 2'b11);
        wait_drain("xor");
        issue(1, OP_SLL, 32'h0000_0001, 32'hFFFF_FFE1, 32'h0000_0002, 1'b0, 2'b11);
        wait_drain("sll");
        issue(0, OP_SRL, 32'h8000_0000, 32'h0000_003F, 32'h0000_0001, 1'b0, 2'b11);
        wait_drain("srl");
        issue(1, OP_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 2'b11);
        wait_drain("sub");

        // Reset while HOLD is pending: everything clears, nothing emerges.
        issue(1, OP_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 2'b00);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("arst_rsp_valid", {30'd0, rsp_valid_out}, 32'd0);
        chk("arst_result", rsp_result_out, 32'd0);
        chk("arst_err", {31'd0, rsp_err_out}, 32'd0);
        chk("arst_busy", {31'd0, busy_out}, 32'd0);
        chk("arst_req_ready", {30'd0, req_ready_out}, 32'd0);
        sb_q.delete();
        @(posedge clk_in);
        #1;
        rst_n_in     = 1'b1;
        rsp_ready_in = 2'b11;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_in);
            chk("post_rst_quiet", {30'd0, rsp_valid_out}, 32'd0);
        end
        @(posedge clk_in);
        #1;
        set_req(0, OP_ADD, 32'd2, 32'd2);
        set_req(1, OP_ADD, 32'd7, 32'd7);
        req_valid_in = 2'b11;
        @(negedge clk_in);
        chk("post_rst_grant", {30'd0, req_ready_out}, 32'd1);
        if (req_ready_out == 2'b01) push_exp(0, 32'd4, 1'b0);
        @(posedge clk_in);
        #1;
        req_valid_in = 2'b00;
        wait_drain("post_rst");

        repeat (3) @(negedge clk_in);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
